addr_trace_replayer: RTL

//  Replays a stored 32-bit address trace (the ICACHE/DCACHE trace format: one address per entry)
//  as valid/ready read requests to a memory-side consumer. Each accepted address runs through a

---
 rtl/trace_pkg.sv | 25 ++
 rtl/dm_tag_model.sv | 66 ++++++
 rtl/addr_trace_replayer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// ============================================================================
// Module : trace_pkg
// Brief  : Shared state encoding and default geometry for the trace replayer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    localparam int DEPTH_LOG2_DEF = 8;
    localparam int LINE_LOG2_DEF  = 4;
    localparam int SETS_LOG2_DEF  = 5;
    localparam int CNT_W_DEF      = 16;
    localparam int ADDR_W         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dm_tag_model.sv
// ============================================================================
// Module : dm_tag_model
// Brief  : Direct-mapped tag store; combinational hit, line fill on a missed lookup.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_tag_model
    import trace_pkg::*;
#(
    parameter int LINE_LOG2 = LINE_LOG2_DEF,
    parameter int SETS_LOG2 = SETS_LOG2_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              lookup_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o
);

    localparam int SETS  = 2 ** SETS_LOG2;
    localparam int TAG_W = ADDR_W - LINE_LOG2 - SETS_LOG2;

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      valid_d;
    logic [TAG_W-1:0]     tag_q [SETS];
    logic [SETS_LOG2-1:0] set_w;
    logic [TAG_W-1:0]     tag_w;
    logic                 fill_w;
    logic                 unused_offset;

    assign set_w         = addr_i[LINE_LOG2+SETS_LOG2-1:LINE_LOG2];
    assign tag_w         = addr_i[ADDR_W-1:LINE_LOG2+SETS_LOG2];
    assign unused_offset = ^addr_i[LINE_LOG2-1:0];

    assign hit_o  = valid_q[set_w] && (tag_q[set_w] == tag_w);
    assign fill_w = lookup_i && !hit_o && !clear_i;

    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else if (fill_w) begin
            valid_d[set_w] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage is qualified by valid bits, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && fill_w) begin
            tag_q[set_w] <= tag_w;
        end
    end

endmodule

`default_nettype wire

// File: rtl/addr_trace_replayer.sv
// ============================================================================
// Module : addr_trace_replayer
// Brief  : Replays a stored address trace as valid/ready requests, counting hits/misses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_trace_replayer
    import trace_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LINE_LOG2  = LINE_LOG2_DEF,
    parameter int SETS_LOG2  = SETS_LOG2_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DEPTH_LOG2:0]   len_i,
    input  logic                  ld_we_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [ADDR_W-1:0]     ld_data_i,
    output logic                  req_valid_o,
    output logic [ADDR_W-1:0]     req_addr_o,
    input  logic                  req_ready_i,
    output logic [CNT_W-1:0]      hit_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LEN_W = DEPTH_LOG2 + 1;

    logic [ADDR_W-1:0] ram_q [DEPTH];

    state_e            state_q,     state_d;
    logic [LEN_W-1:0]  idx_q,       idx_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q,   hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              ram_we_w;
    logic [LEN_W-1:0]  len_clamp_w;
    logic [LEN_W-1:0]  idx_next_w;
    logic              tag_clear_w;
    logic              tag_lookup_w;
    logic              tag_hit_w;

    assign ram_we_w    = rst_i && ld_we_i && (state_q == IDLE);
    assign len_clamp_w = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;
    assign idx_next_w  = idx_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (ram_we_w) begin
            ram_q[ld_addr_i] <= ld_data_i;
        end
    end

    dm_tag_model #(
        .LINE_LOG2 (LINE_LOG2),
        .SETS_LOG2 (SETS_LOG2)
    ) u_tags (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (tag_clear_w),
        .lookup_i (tag_lookup_w),
        .addr_i   (req_addr_q),
        .hit_o    (tag_hit_w)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tag_clear_w  = 1'b0;
        tag_lookup_w = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d       = len_clamp_w;
                    idx_d       = '0;
                    hit_cnt_d   = '0;
                    miss_cnt_d  = '0;
                    tag_clear_w = 1'b1;
                    state_d     = (len_clamp_w == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                req_addr_d  = ram_q[idx_q[DEPTH_LOG2-1:0]];
                req_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (req_valid_q && req_ready_i) begin
                    tag_lookup_w = 1'b1;
                    if (tag_hit_w) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                    req_valid_d = 1'b0;
                    if (idx_next_w == len_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_next_w;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status flags track the state being entered so they stay registered.
        busy_d = (state_d == FETCH) || (state_d == ISSUE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

`default_nettype wire
